lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the core's memory stage and the data RAM's byte/half/word port.
- Accepts one request at a time. Issues it to the RAM as one access when the RAM can serve it directly. Otherwise splits it into little-endian byte beats.
- Re-assembles load data, applies the final sign/zero extension, and returns a single-cycle response.

---
 rtl/lsu_mem_ctrl_pkg.sv | 25 ++
 rtl/lsu_split_plan.sv | 48 ++++
 rtl/lsu_mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_ctrl_pkg
// Brief   : RAM access-mode codes and LSU state encoding shared by the
//           load/store controller and its split planner.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_mem_ctrl_pkg;

  // RAM port width codes (match the RAM's existing mode defines)
  localparam logic [1:0] RAM_MODE_BYTE    = 2'd0;
  localparam logic [1:0] RAM_MODE_HALF    = 2'd1;
  localparam logic [1:0] RAM_MODE_WORD    = 2'd2;
  localparam logic [1:0] RAM_MODE_ILLEGAL = 2'd3;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_LAST_RD = 2'd2,
    S_RESP    = 2'd3
  } lsu_state_t;

endpackage : lsu_mem_ctrl_pkg
`default_nettype wire

// File: rtl/lsu_split_plan.sv
`default_nettype none
// ============================================================================
// Module  : lsu_split_plan
// Brief   : Decides from access width and address offset whether a request
//           goes to the RAM as one direct access or as little-endian byte
//           beats, how many beats it needs, and whether the mode is illegal.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_split_plan
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic [1:0] i_off,
  output logic       o_split,
  output logic [2:0] o_beats,
  output logic       o_illegal
);

  // The RAM handles any access that stays inside one aligned word
  always_comb begin
    o_split   = 1'b0;
    o_beats   = 3'd1;
    o_illegal = 1'b0;
    case (i_mode)
      RAM_MODE_BYTE: begin
        o_beats = 3'd1;
      end
      RAM_MODE_HALF: begin
        if (i_off == 2'd3) begin
          o_split = 1'b1;
          o_beats = 3'd2;
        end
      end
      RAM_MODE_WORD: begin
        if (i_off != 2'd0) begin
          o_split = 1'b1;
          o_beats = 3'd4;
        end
      end
      default: begin
        o_illegal = 1'b1;
        o_beats   = 3'd0;
      end
    endcase
  end

endmodule : lsu_split_plan
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_ctrl
// Brief   : Load/store initiator between the memory stage and the data RAM.
//           Issues direct accesses or byte-beat splits, reassembles split
//           load data and returns a single-cycle response.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [1:0]        i_req_mode,
  input  logic              i_req_signed,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_r_addr,
  output logic [ADDR_W-1:0] o_ram_w_addr,
  output logic [DATA_W-1:0] o_ram_w_data,
  output logic [1:0]        o_ram_write_mode,
  output logic [1:0]        o_ram_read_mode,
  output logic              o_ram_read_signed,
  input  logic [DATA_W-1:0] i_ram_r_data
);

  lsu_state_t        r_state;
  logic              r_we;
  logic              r_signed;
  logic              r_split;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_mode;
  logic [1:0]        r_last;   // index of the final beat (beat count - 1)
  logic [1:0]        r_beat;
  logic [DATA_W-1:0] r_asm;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic              w_split;
  logic              w_illegal;
  logic [2:0]        w_beats;
  logic [ADDR_W-1:0] w_beat_addr;
  logic [1:0]        w_prev_beat;
  logic [DATA_W-1:0] w_asm_final;
  logic [DATA_W-1:0] w_load_result;

  lsu_split_plan u_plan (
    .i_mode    (i_req_mode),
    .i_off     (i_req_addr[1:0]),
    .o_split   (w_split),
    .o_beats   (w_beats),
    .o_illegal (w_illegal)
  );

  // Beat addresses wrap naturally at the address width
  assign w_beat_addr = r_addr + ADDR_W'(r_beat);
  assign w_prev_beat = r_beat - 2'd1;

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

  // RAM port is driven only while issuing; decoding from state lets reset kill ram_we at once
  always_comb begin
    o_ram_we          = 1'b0;
    o_ram_r_addr      = '0;
    o_ram_w_addr      = '0;
    o_ram_w_data      = '0;
    o_ram_write_mode  = RAM_MODE_BYTE;
    o_ram_read_mode   = RAM_MODE_BYTE;
    o_ram_read_signed = 1'b0;
    if (r_state == S_ISSUE) begin
      o_ram_we     = r_we;
      o_ram_r_addr = w_beat_addr;
      o_ram_w_addr = w_beat_addr;
      if (r_split) begin
        o_ram_w_data = {{(DATA_W-8){1'b0}}, r_wdata[{r_beat, 3'b000} +: 8]};
      end else begin
        o_ram_w_data      = r_wdata;
        o_ram_write_mode  = r_mode;
        o_ram_read_mode   = r_mode;
        o_ram_read_signed = r_signed;
      end
    end
  end

  // Final load value: direct reads come pre-extended from the RAM, split reads are rebuilt here
  always_comb begin
    w_asm_final = r_asm;
    w_asm_final[{r_last, 3'b000} +: 8] = i_ram_r_data[7:0];
    if (!r_split) begin
      w_load_result = i_ram_r_data;
    end else if (r_mode == RAM_MODE_HALF) begin
      w_load_result = {{16{r_signed & w_asm_final[15]}}, w_asm_final[15:0]};
    end else begin
      w_load_result = w_asm_final;
    end
  end

  // Request FSM, beat counter, load assembly and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_signed     <= 1'b0;
      r_split      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mode       <= RAM_MODE_BYTE;
      r_last       <= 2'd0;
      r_beat       <= 2'd0;
      r_asm        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we     <= i_req_we;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_mode   <= i_req_mode;
            r_signed <= i_req_signed;
            r_split  <= w_split;
            r_last   <= 2'(w_beats - 3'd1);
            r_beat   <= 2'd0;
            if (w_illegal) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Data of the previous beat is on the RAM output this cycle
          if (!r_we && (r_beat != 2'd0)) begin
            r_asm[{w_prev_beat, 3'b000} +: 8] <= i_ram_r_data[7:0];
          end
          if (r_beat == r_last) begin
            if (r_we) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
            end else begin
              r_state <= S_LAST_RD;
            end
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        S_LAST_RD: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_load_result;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : lsu_mem_ctrl
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mem_ctrl
// Brief   : Self-checking bench for lsu_mem_ctrl with a behavioural byte RAM
//           and a byte-array reference model of memory contents.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_mode;
  logic        req_signed;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_we;
  logic [15:0] ram_r_addr;
  logic [15:0] ram_w_addr;
  logic [31:0] ram_w_data;
  logic [1:0]  ram_write_mode;
  logic [1:0]  ram_read_mode;
  logic        ram_read_signed;
  logic [31:0] ram_r_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rd;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         loaded = 1'b0;

  lsu_mem_ctrl #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_we          (req_we),
    .i_req_addr        (req_addr),
    .i_req_wdata       (req_wdata),
    .i_req_mode        (req_mode),
    .i_req_signed      (req_signed),
    .o_resp_valid      (resp_valid),
    .o_resp_rdata      (resp_rdata),
    .o_resp_err        (resp_err),
    .o_ram_we          (ram_we),
    .o_ram_r_addr      (ram_r_addr),
    .o_ram_w_addr      (ram_w_addr),
    .o_ram_w_data      (ram_w_data),
    .o_ram_write_mode  (ram_write_mode),
    .o_ram_read_mode   (ram_read_mode),
    .o_ram_read_signed (ram_read_signed),
    .i_ram_r_data      (ram_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 8));
  endfunction

  // RAM read port: little-endian, width and extension chosen by the read mode
  function automatic logic [31:0] ram_read(input logic [15:0] a, input logic [1:0] m, input logic s);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a];
    b1 = mem[16'(a + 16'd1)];
    b2 = mem[16'(a + 16'd2)];
    b3 = mem[16'(a + 16'd3)];
    case (m)
      2'd0:    return s ? {{24{b0[7]}}, b0} : {24'd0, b0};
      2'd1:    return s ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // Behavioural data RAM: registered read, byte/half/word write
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
      loaded <= 1'b1;
    end else begin
      ram_r_data <= ram_read(ram_r_addr, ram_read_mode, ram_read_signed);
      if (ram_we) begin
        mem[ram_w_addr] <= ram_w_data[7:0];
        if (ram_write_mode != 2'd0) mem[16'(ram_w_addr + 16'd1)] <= ram_w_data[15:8];
        if (ram_write_mode == 2'd2) begin
          mem[16'(ram_w_addr + 16'd2)] <= ram_w_data[23:16];
          mem[16'(ram_w_addr + 16'd3)] <= ram_w_data[31:24];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [1:0] m);
    return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
  endfunction

  // Accesses crossing a word boundary go byte by byte
  function automatic int beats_of(input logic [1:0] m, input logic [15:0] a);
    int off;
    off = int'(a[1:0]);
    if (off + size_of(m) > 4) return size_of(m);
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [15:0] a, input logic [1:0] m, input logic s);
    longint v;
    int n;
    n = size_of(m);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[16'(a + 16'(i))]) << (8 * i));
    if (s && n < 4 && v[8*n-1]) v = v | ~((longint'(1) << (8 * n)) - 1);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [15:0] a, input logic [1:0] m, input logic [31:0] d);
    for (int i = 0; i < size_of(m); i++) ref_mem[16'(a + 16'(i))] = d[8*i +: 8];
  endtask

  // Issue one request and observe its response; lat is -1 if none arrives
  task automatic do_req(input logic we, input logic [15:0] a, input logic [31:0] wd,
                        input logic [1:0] m, input logic s,
                        output logic [31:0] rd, output logic err, output int lat,
                        output int nwe, output logic nxt_valid);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = wd;
    req_mode   = m;
    req_signed = s;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = -1; nwe = 0; rd = 'x; err = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ram_we) nwe++;
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
    end
    @(negedge clk);
    nxt_valid = resp_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_mode = '0; req_signed = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1)   begin n_errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0)  begin n_errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0)    begin n_errors++; $display("FAIL reset_err got %b want 0", resp_err); end
    n_checks++; if (ram_we !== 1'b0)      begin n_errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
    n_checks++;
    if ({ram_r_addr, ram_w_addr, ram_w_data, ram_write_mode, ram_read_mode, ram_read_signed} !== 69'd0) begin
      n_errors++;
      $display("FAIL reset_ram_outs got %h/%h/%h/%0d/%0d/%b want all 0",
               ram_r_addr, ram_w_addr, ram_w_data, ram_write_mode, ram_read_mode, ram_read_signed);
    end
    last_rd = 32'd0;
  endtask

  task automatic test_aligned_word();
    logic [31:0] rd; logic err, nv; int lat, nwe;
    do_req(1'b1, 16'h0010, 32'hDEADBEEF, 2'd2, 1'b0, rd, err, lat, nwe, nv);
    ref_store(16'h0010, 2'd2, 32'hDEADBEEF);
    n_checks++; if (nwe != 1)  begin n_errors++; $display("FAIL aw_store_we_cycles got %0d want 1", nwe); end
    n_checks++; if (lat != 2)  begin n_errors++; $display("FAIL aw_store_latency got %0d want 2", lat); end
    n_checks++; if (rd !== last_rd) begin n_errors++; $display("FAIL aw_store_rdata_held got %h want %h", rd, last_rd); end
    n_checks++; if (nv !== 1'b0) begin n_errors++; $display("FAIL aw_store_pulse got %b want 0", nv); end
    do_req(1'b0, 16'h0010, 32'd0, 2'd2, 1'b0, rd, err, lat, nwe, nv);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL aw_load_data got %h want deadbeef", rd); end
    n_checks++; if (lat != 3)  begin n_errors++; $display("FAIL aw_load_latency got %0d want 3", lat); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL aw_load_err got %b want 0", err); end
    last_rd = rd;
  endtask

  task automatic test_half_ext();
    logic [31:0] rd; logic err, nv; int lat, nwe;
    do_req(1'b1, 16'h0010, 32'h80017FFF, 2'd2, 1'b0, rd, err, lat, nwe, nv);
    ref_store(16'h0010, 2'd2, 32'h80017FFF);
    do_req(1'b0, 16'h0012, 32'd0, 2'd1, 1'b1, rd, err, lat, nwe, nv);
    n_checks++; if (rd !== 32'hFFFF8001) begin n_errors++; $display("FAIL half_signed got %h want ffff8001", rd); end
    n_checks++; if (lat != 3) begin n_errors++; $display("FAIL half_signed_latency got %0d want 3", lat); end
    do_req(1'b0, 16'h0012, 32'd0, 2'd1, 1'b0, rd, err, lat, nwe, nv);
    n_checks++; if (rd !== 32'h00008001) begin n_errors++; $display("FAIL half_unsigned got %h want 00008001", rd); end
    last_rd = rd;
  endtask

  task automatic test_split_half();
    logic [31:0] rd; logic err, nv; int lat, nwe;
    do_req(1'b1, 16'h0003, 32'h0000A55A, 2'd1, 1'b0, rd, err, lat, nwe, nv);
    ref_store(16'h0003, 2'd1, 32'h0000A55A);
    n_checks++; if (nwe != 2) begin n_errors++; $display("FAIL sh_store_we_cycles got %0d want 2", nwe); end
    n_checks++; if (lat != 3) begin n_errors++; $display("FAIL sh_store_latency got %0d want 3", lat); end
    n_checks++; if (mem[16'h0003] !== 8'h5A || mem[16'h0004] !== 8'hA5) begin
      n_errors++; $display("FAIL sh_store_bytes got %h %h want 5a a5", mem[16'h0003], mem[16'h0004]);
    end
    do_req(1'b0, 16'h0003, 32'd0, 2'd1, 1'b1, rd, err, lat, nwe, nv);
    n_checks++; if (rd !== 32'hFFFFA55A) begin n_errors++; $display("FAIL sh_load got %h want ffffa55a", rd); end
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL sh_load_latency got %0d want 4", lat); end
    last_rd = rd;
  endtask

  task automatic test_wrap_word();
    logic [31:0] rd; logic err, nv; int lat, nwe;
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 16'(16'hFFFE + 16'(i));
      do_req(1'b1, a, 32'(8'h11 * (i + 1)), 2'd0, 1'b0, rd, err, lat, nwe, nv);
      ref_store(a, 2'd0, 32'(8'h11 * (i + 1)));
    end
    do_req(1'b0, 16'hFFFE, 32'd0, 2'd2, 1'b0, rd, err, lat, nwe, nv);
    n_checks++; if (rd !== 32'h44332211) begin n_errors++; $display("FAIL wrap_load got %h want 44332211", rd); end
    n_checks++; if (lat != 6) begin n_errors++; $display("FAIL wrap_latency got %0d want 6", lat); end
    n_checks++; if (nwe != 0) begin n_errors++; $display("FAIL wrap_load_we got %0d want 0", nwe); end
    last_rd = rd;
  endtask

  task automatic test_illegal_back_to_back();
    logic [31:0] exp;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040; req_wdata = 32'h12345678; req_mode = 2'd3; req_signed = 1'b0;
    @(posedge clk);
    #1;
    // Next request presented while the illegal one is still responding
    req_we = 1'b0; req_addr = 16'h0011; req_mode = 2'd0; req_signed = 1'b0;
    exp = ref_load(16'h0011, 2'd0, 1'b0);
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b1) begin n_errors++; $display("FAIL ill_resp_valid got %b want 1", resp_valid); end
    n_checks++; if (resp_err !== 1'b1)   begin n_errors++; $display("FAIL ill_err got %b want 1", resp_err); end
    n_checks++; if (resp_rdata !== 32'd0) begin n_errors++; $display("FAIL ill_rdata got %h want 0", resp_rdata); end
    n_checks++; if (ram_we !== 1'b0)     begin n_errors++; $display("FAIL ill_ram_we got %b want 0", ram_we); end
    n_checks++; if (req_ready !== 1'b0)  begin n_errors++; $display("FAIL ill_ready_c1 got %b want 0", req_ready); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1)  begin n_errors++; $display("FAIL ill_ready_c2 got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL ill_pulse got %b want 0", resp_valid); end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        n_checks++; if (resp_rdata !== exp) begin n_errors++; $display("FAIL b2b_data got %h want %h", resp_rdata, exp); end
        n_checks++; if (resp_err !== 1'b0) begin n_errors++; $display("FAIL b2b_err got %b want 0", resp_err); end
        break;
      end
    end
    n_checks++; if (lat != 3) begin n_errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
    last_rd = exp;
  endtask

  task automatic test_reset_mid_store();
    logic [7:0] old2, old3;
    bit saw;
    old2 = ref_mem[16'h0023];
    old3 = ref_mem[16'h0024];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0021; req_wdata = 32'h11223344; req_mode = 2'd2; req_signed = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;   // beat 0
    @(posedge clk); #1;                     // beat 1
    @(posedge clk); #1;                     // beat 2
    n_checks++; if (ram_we !== 1'b1) begin n_errors++; $display("FAIL rm_beat2_we got %b want 1", ram_we); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ram_we !== 1'b0)    begin n_errors++; $display("FAIL rm_we_drop got %b want 0", ram_we); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rm_ready got %b want 1", req_ready); end
    saw = 1'b0;
    repeat (2) begin @(negedge clk); if (resp_valid) saw = 1'b1; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (resp_valid) saw = 1'b1; end
    n_checks++; if (saw) begin n_errors++; $display("FAIL rm_no_resp got pulse want none"); end
    ref_mem[16'h0021] = 8'h44;
    ref_mem[16'h0022] = 8'h33;
    n_checks++;
    if (mem[16'h0021] !== 8'h44 || mem[16'h0022] !== 8'h33 || mem[16'h0023] !== old2 || mem[16'h0024] !== old3) begin
      n_errors++;
      $display("FAIL rm_bytes got %h %h %h %h want 44 33 %h %h",
               mem[16'h0021], mem[16'h0022], mem[16'h0023], mem[16'h0024], old2, old3);
    end
    last_rd = 32'd0;
  endtask

  task automatic test_random();
    logic [31:0] rd, exp, wd; logic err, nv, we, s; int lat, nwe, n, sel, bad;
    logic [1:0] m; logic [15:0] a;
    for (int t = 0; t < 60; t++) begin
      we  = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      wd  = $urandom;
      sel = $urandom_range(0, 9);
      m   = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      a   = ($urandom_range(0, 1) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 15)))
                                        : 16'(16'h0100 + 16'($urandom_range(0, 31)));
      do_req(we, a, wd, m, s, rd, err, lat, nwe, nv);
      n_checks++; if (nv !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_pulse got %b want 0", t, nv); end
      if (m == 2'd3) begin
        n_checks++;
        if (err !== 1'b1 || rd !== 32'd0 || lat != 1 || nwe != 0) begin
          n_errors++;
          $display("FAIL rnd%0d_illegal got err=%b rd=%h lat=%0d we=%0d want 1 0 1 0", t, err, rd, lat, nwe);
        end
        last_rd = 32'd0;
      end else if (we) begin
        n = beats_of(m, a);
        ref_store(a, m, wd);
        n_checks++;
        if (err !== 1'b0 || rd !== last_rd || lat != n + 1 || nwe != n) begin
          n_errors++;
          $display("FAIL rnd%0d_store a=%h m=%0d got err=%b rd=%h lat=%0d we=%0d want 0 %h %0d %0d",
                   t, a, m, err, rd, lat, nwe, last_rd, n + 1, n);
        end
      end else begin
        n = beats_of(m, a);
        exp = ref_load(a, m, s);
        n_checks++;
        if (err !== 1'b0 || rd !== exp || lat != n + 2 || nwe != 0) begin
          n_errors++;
          $display("FAIL rnd%0d_load a=%h m=%0d s=%b got err=%b rd=%h lat=%0d we=%0d want 0 %h %0d 0",
                   t, a, m, s, err, rd, lat, nwe, exp, n + 2);
        end
        last_rd = exp;
      end
    end
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL mem_image got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    test_reset();
    test_aligned_word();
    test_half_ext();
    test_split_half();
    test_wrap_word();
    test_illegal_back_to_back();
    test_reset_mid_store();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_lsu_mem_ctrl
`default_nettype wire
